// File: rtl/demux13_rr_sched_if.sv
// Bundle of handshake and status signals between the word source, the
// round-robin scheduler and the 7 channel sinks.
//
// Handshake rule, which applies to both the input side (in_valid/in_ready) and
// the output side (out_valid[i]/out_ready[i]):
//   a transfer happens on a rising clk edge where valid and ready are both high.
//   Once valid is raised, it and its data stay stable until that edge.
//   Ready may be raised or dropped at any time.
//
// Modports:
//   master : source/sink side; drives in_data, in_valid, chan_en and out_ready
//   slave  : scheduler side; drives in_ready, sel, out_data, out_valid, busy,
//            word_cnt and dbg_state (the FSM state, for checkers)
interface demux13_rr_sched_if #(
    parameter int W     = 13,
    parameter int NCH   = 7,
    parameter int CNT_W = 16
);
    logic [W-1:0]     in_data;
    logic             in_valid;
    logic             in_ready;
    logic [NCH-1:0]   chan_en;
    logic [NCH-1:0]   out_ready;
    logic [2:0]       sel;
    logic [W-1:0]     out_data;
    logic [NCH-1:0]   out_valid;
    logic             busy;
    logic [CNT_W-1:0] word_cnt;
    logic [1:0]       dbg_state;

    modport master (
        output in_data, in_valid, chan_en, out_ready,
        input  in_ready, sel, out_data, out_valid, busy, word_cnt, dbg_state
    );

    modport slave (
        input  in_data, in_valid, chan_en, out_ready,
        output in_ready, sel, out_data, out_valid, busy, word_cnt, dbg_state
    );
endinterface

// File: rtl/demux13_rr_sched.sv
// Round-robin scheduler in front of the 13-bit 1-to-7 demux.
// Takes one word at a time from the source, holds it, picks the next enabled
// channel after the last one served, and offers the word on that channel with
// a one-hot valid until the channel's sink accepts it.
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   reset  - synchronous, active-high
//   bus    - demux13_rr_sched_if.slave:
//              in_data/in_valid/in_ready  word input handshake
//              chan_en                    per-channel enable (looked at only while arbitrating)
//              out_ready                  per-channel sink ready
//              sel                        demux select, 3'b111 when no channel active
//              out_data/out_valid         held word and one-hot valid
//              busy                       high while arbitrating or sending
//              word_cnt                   delivered-word counter, wraps
//              dbg_state                  FSM state
module demux13_rr_sched #(
    parameter int W       = 13,
    parameter int NCH     = 7,
    parameter bit REVERSE = 1'b1,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    demux13_rr_sched_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        SEND = 2'd2
    } state_t;

    localparam logic [2:0] NO_SEL = 3'b111;

    state_t           state;
    logic [2:0]       ptr;
    logic [2:0]       sel_q;
    logic [NCH-1:0]   out_valid_q;
    logic [W-1:0]     out_data_q;
    logic [CNT_W-1:0] word_cnt_q;
    logic             in_ready_q;

    logic             arb_found;
    logic [2:0]       arb_idx;
    logic [3:0]       cand;
    logic             out_hs;

    function automatic logic [W-1:0] bitrev(input logic [W-1:0] d);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) begin
            r[i] = d[W-1-i];
        end
        return r;
    endfunction

    // First enabled channel at or after ptr, wrapping at NCH.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = NO_SEL;
        cand      = '0;
        for (int k = 0; k < NCH; k++) begin
            cand = {1'b0, ptr} + 4'(k);
            if (cand >= 4'(NCH)) begin
                cand = cand - 4'(NCH);
            end
            if (!arb_found && bus.chan_en[cand[2:0]]) begin
                arb_found = 1'b1;
                arb_idx   = cand[2:0];
            end
        end
    end

    // out_valid is one-hot, so any overlap with out_ready is the selected
    // channel's handshake; ready on other channels cannot match.
    assign out_hs = |(out_valid_q & bus.out_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            sel_q       <= NO_SEL;
            out_valid_q <= '0;
            out_data_q  <= '0;
            word_cnt_q  <= '0;
            in_ready_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // in_ready comes up one cycle after reset release.
                    if (!in_ready_q) begin
                        in_ready_q <= 1'b1;
                    end else if (bus.in_valid) begin
                        out_data_q <= REVERSE ? bitrev(bus.in_data) : bus.in_data;
                        in_ready_q <= 1'b0;
                        state      <= ARB;
                    end
                end
                ARB: begin
                    // With nothing enabled the word waits here indefinitely.
                    if (arb_found) begin
                        sel_q       <= arb_idx;
                        out_valid_q <= NCH'(1) << arb_idx;
                        state       <= SEND;
                    end
                end
                SEND: begin
                    // chan_en is not looked at here: a started transfer completes.
                    if (out_hs) begin
                        ptr         <= (sel_q == 3'(NCH-1)) ? 3'd0 : sel_q + 3'd1;
                        word_cnt_q  <= word_cnt_q + CNT_W'(1);
                        out_valid_q <= '0;
                        sel_q       <= NO_SEL;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    sel_q       <= NO_SEL;
                    out_valid_q <= '0;
                    in_ready_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.sel       = sel_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.word_cnt  = word_cnt_q;
    assign bus.busy      = (state != IDLE);
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_demux13_rr_sched.sv
module tb_demux13_rr_sched;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    demux13_rr_sched_if #(.W(13), .NCH(7), .CNT_W(16)) bus0 ();
    demux13_rr_sched_if #(.W(13), .NCH(7), .CNT_W(3))  bus1 ();

    demux13_rr_sched #(.W(13), .NCH(7), .REVERSE(1'b1), .CNT_W(16)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0)
    );
    demux13_rr_sched #(.W(13), .NCH(7), .REVERSE(1'b0), .CNT_W(3)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    int checks = 0;
    int errors = 0;
    bit started = 0;
    bit rand_ready = 0;

    // ---------------- reference model ----------------
    // Expected entry = {channel[2:0], data[12:0]}.
    logic [15:0] exp_q[$];
    logic [15:0] exp1_q[$];
    int m_ptr = 0;
    int m1_ptr = 0;
    logic [15:0] sb_cnt = '0;
    logic [2:0]  sb1_cnt = '0;

    function automatic int pick(input logic [6:0] en, input int p);
        for (int k = 0; k < 7; k++) begin
            if (en[(p + k) % 7]) return (p + k) % 7;
        end
        return -1;
    endfunction

    task automatic push0(input logic [12:0] d, input logic [6:0] en);
        int c;
        logic [12:0] r;
        c = pick(en, m_ptr);
        if (c >= 0) begin
            r = {<<{d}};
            exp_q.push_back({3'(c), r});
            m_ptr = (c + 1) % 7;
        end
    endtask

    task automatic fail(input string name, input logic [31:0] act, input logic [31:0] req);
        errors++;
        $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) fail(name, act, req);
    endtask

    // ---------------- monitors / scoreboards ----------------
    always @(negedge clk) begin
        logic [15:0] e;
        if (reset) begin
            sb_cnt = '0;
        end else if (started) begin
            checks++;
            if (!((bus0.out_valid == '0 || $onehot(bus0.out_valid)) &&
                  ((bus0.sel == 3'b111) == (bus0.out_valid == '0))))
                fail("inv_sel_valid", {bus0.sel, 7'b0, bus0.out_valid}, 0);
            check("word_cnt0", bus0.word_cnt, sb_cnt);
            if ((bus0.out_valid & bus0.out_ready) != '0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fail("unexpected_delivery0", {bus0.sel, bus0.out_data}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("delivery0", {bus0.sel, bus0.out_data}, e);
                    sb_cnt++;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [15:0] e;
        if (reset) begin
            sb1_cnt = '0;
        end else if (started) begin
            check("word_cnt1", bus1.word_cnt, sb1_cnt);
            if ((bus1.out_valid & bus1.out_ready) != '0) begin
                if (exp1_q.size() == 0) begin
                    checks++;
                    fail("unexpected_delivery1", {bus1.sel, bus1.out_data}, 0);
                end else begin
                    e = exp1_q.pop_front();
                    check("delivery1", {bus1.sel, bus1.out_data}, e);
                    sb1_cnt++;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 bus0.out_ready = 7'($urandom);
        end
    end

    // ---------------- driver tasks (all called at posedge + #1) ----------------
    task automatic send0(input logic [12:0] d, input logic [6:0] en, input bit push);
        int t = 0;
        while (bus0.in_ready !== 1'b1 && t < 500) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 500) begin checks++; fail("send0_timeout", t, 500); end
        bus0.chan_en  = en;
        bus0.in_data  = d;
        bus0.in_valid = 1'b1;
        if (push) push0(d, en);
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
    endtask

    task automatic send1(input logic [12:0] d);
        int t = 0;
        while (bus1.in_ready !== 1'b1 && t < 500) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 500) begin checks++; fail("send1_timeout", t, 500); end
        bus1.in_data  = d;
        bus1.in_valid = 1'b1;
        exp1_q.push_back({3'(m1_ptr), d});
        m1_ptr = (m1_ptr + 1) % 7;
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
    endtask

    task automatic wait_send0();
        int t = 0;
        while (bus0.out_valid == '0 && t < 20) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 20) begin checks++; fail("wait_send0_timeout", t, 20); end
    endtask

    task automatic drain(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || exp1_q.size() != 0) && t < 2000) begin
            @(posedge clk); #1; t++;
        end
        @(posedge clk); #1;
        if (t >= 2000) begin checks++; fail(name, exp_q.size() + exp1_q.size(), 0); end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        bus0.in_valid = 1'b0;
        bus1.in_valid = 1'b0;
        exp_q.delete();
        exp1_q.delete();
        m_ptr = 0;
        m1_ptr = 0;
        @(posedge clk); #1;
        check("rst_sel", bus0.sel, 3'b111);
        check("rst_out_valid", bus0.out_valid, 0);
        check("rst_out_data", bus0.out_data, 0);
        check("rst_word_cnt", bus0.word_cnt, 0);
        check("rst_busy", bus0.busy, 0);
        check("rst_in_ready", bus0.in_ready, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("in_ready_after_rst", bus0.in_ready, 1);
        started = 1;
    endtask

    // ---------------- stimulus ----------------
    logic [12:0]  snap_data;
    logic [2:0]   snap_sel;
    logic [6:0]   snap_valid;

    initial begin
        bus0.in_valid = 0; bus0.in_data = '0; bus0.chan_en = 7'h7F; bus0.out_ready = 7'h7F;
        bus1.in_valid = 0; bus1.in_data = '0; bus1.chan_en = 7'h7F; bus1.out_ready = 7'h7F;
        do_reset();

        // 1: all channels enabled, words 1..7 go to channels 0..6
        for (int i = 1; i <= 7; i++) send0(13'(i), 7'h7F, 1);
        drain("drain_t1");
        check("t1_word_cnt", bus0.word_cnt, 7);

        // 2: only channels 2 and 5 enabled
        for (int i = 0; i < 4; i++) send0(13'($urandom), 7'b0100100, 1);
        drain("drain_t2");

        // 3: nothing enabled, word is held in arbitration
        send0(13'h1ABC, 7'h00, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("t3_sel_held", bus0.sel, 3'b111);
            check("t3_in_ready", bus0.in_ready, 0);
            check("t3_valid", {bus0.busy, bus0.out_valid}, 8'h80);
        end
        bus0.chan_en = 7'h01;
        push0(13'h1ABC, 7'h01);
        begin
            int t = 0;
            while (bus0.out_valid == '0 && t < 2) begin @(posedge clk); #1; t++; end
        end
        check("t3_after_enable", {bus0.sel, bus0.out_valid}, {3'd0, 7'h01});
        drain("drain_t3");

        // 4: channel 3 stalls while other channels are ready
        bus0.out_ready = 7'b1110111;
        send0(13'($urandom), 7'b0001000, 1);
        wait_send0();
        snap_sel = bus0.sel; snap_data = bus0.out_data; snap_valid = bus0.out_valid;
        check("t4_sel", snap_sel, 3);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("t4_stable", {bus0.sel, bus0.out_valid, bus0.out_data},
                  {snap_sel, snap_valid, snap_data});
        end
        bus0.out_ready = 7'h7F;
        drain("drain_t4");
        check("t4_idle", {bus0.busy, bus0.in_ready}, 2'b01);
        send0(13'($urandom), 7'h7F, 1);   // model expects channel 4
        drain("drain_t4b");

        // 5: reset while sending drops the word; next word goes to channel 0
        bus0.out_ready = 7'h00;
        send0(13'($urandom), 7'h7F, 1);
        wait_send0();
        do_reset();
        bus0.out_ready = 7'h7F;
        send0(13'($urandom), 7'h7F, 1);
        drain("drain_t5");

        // random phase: random enables, random sink ready, enables flipped mid-send
        rand_ready = 1;
        for (int i = 0; i < 40; i++) begin
            send0(13'($urandom), 7'($urandom_range(1, 127)), 1);
            wait_send0();
            bus0.chan_en = 7'($urandom);
        end
        drain("drain_rand");
        rand_ready = 0;
        @(posedge clk); #1;
        bus0.out_ready = 7'h7F;

        // 6: pass-through instance with a 3-bit counter wraps after 8 words
        for (int i = 0; i < 9; i++) send1(13'($urandom));
        drain("drain_t6");
        check("t6_word_cnt_wrap", bus1.word_cnt, 1);

        check("final_queue0", exp_q.size(), 0);
        check("final_queue1", exp1_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=%0t required=<500000", $time);
        $fatal(1, "timeout");
    end

endmodule
